// File: rtl/ysyx_23060042_pkg.sv
// Shared types and helpers for the ysyx_23060042 load/store unit.
//   lsu_size_t     : access size encoding carried on req_size (2'b11 is illegal)
//   lsu_state_t    : LSU transaction FSM states
//   LSU_LANES      : byte lanes of the 32-bit data path
//   lsu_misaligned : flags accesses the LSU refuses to issue
//   lsu_extract    : aligns a fetched word and sign/zero-extends the loaded value
package ysyx_23060042_pkg;

  localparam int unsigned LSU_LANES = 4;

  typedef enum logic [1:0] {
    LSU_B = 2'b00,
    LSU_H = 2'b01,
    LSU_W = 2'b10
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_t;

  // Illegal size (2'b11) counts as misaligned so both cases share the error path.
  function automatic logic lsu_misaligned(input logic [1:0] addr_lo,
                                          input logic [1:0] size);
    logic bad;
    case (lsu_size_t'(size))
      LSU_B:   bad = 1'b0;
      LSU_H:   bad = addr_lo[0];
      LSU_W:   bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] lsu_extract(input logic [31:0] rdata,
                                              input logic [1:0]  addr_lo,
                                              input logic [1:0]  size,
                                              input logic        is_unsigned);
    logic [31:0] word;
    logic [31:0] ext;
    word = rdata >> {addr_lo, 3'b000};
    case (lsu_size_t'(size))
      LSU_B:   ext = is_unsigned ? {24'b0, word[7:0]}  : {{24{word[7]}}, word[7:0]};
      LSU_H:   ext = is_unsigned ? {16'b0, word[15:0]} : {{16{word[15]}}, word[15:0]};
      default: ext = word;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/ysyx_23060042_lsu_align.sv
// Combinational byte-lane alignment for the LSU store path.
//   addr_lo    : low two bits of the byte address
//   size       : access size (lsu_size_t encoding)
//   wdata      : LSB-justified store data
//   lane_wdata : store data shifted into its byte lanes
//   wstrb      : byte-lane write strobe (0 for misaligned/illegal accesses)
//   misaligned : access must not be issued to memory
// Load-side extension is the package function lsu_extract, shared with the FSM.
module ysyx_23060042_lsu_align
  import ysyx_23060042_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]           addr_lo,
  input  logic [1:0]           size,
  input  logic [DW-1:0]        wdata,
  output logic [DW-1:0]        lane_wdata,
  output logic [LSU_LANES-1:0] wstrb,
  output logic                 misaligned
);

  logic [LSU_LANES-1:0] base_strb;

  always_comb begin
    case (lsu_size_t'(size))
      LSU_B:   base_strb = 4'b0001;
      LSU_H:   base_strb = 4'b0011;
      LSU_W:   base_strb = 4'b1111;
      default: base_strb = 4'b0000;
    endcase
    misaligned = lsu_misaligned(addr_lo, size);
    lane_wdata = wdata << {addr_lo, 3'b000};
    wstrb      = misaligned ? '0 : (base_strb << addr_lo);
  end

endmodule

// File: rtl/ysyx_23060042_lsu.sv
// Multi-cycle load/store unit: one memory transaction at a time over a
// valid/ready memory port.
//   clk, rst        : core clock, synchronous active-high reset
//   req_*           : request from execute (addr, store flag, size, unsigned, data)
//   resp_*          : extended load data / error back to execute
//   mem_req_*       : word-aligned memory request with lane data and strobe
//   mem_resp_valid  : one-cycle read data / write ack pulse, mem_rdata the word
// Misaligned or illegal-size requests go straight to RESP with resp_err set.
module ysyx_23060042_lsu
  import ysyx_23060042_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic          req_wen,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_rdata
);

  lsu_state_t state, next_state;

  logic [1:0] addr_lo_q;
  logic [1:0] size_q;
  logic       unsigned_q;
  logic       wen_q;

  logic [DW-1:0]        lane_wdata;
  logic [LSU_LANES-1:0] lane_strb;
  logic                 misaligned;

  logic accept;
  logic capture;

  // Lane data/strobe are computed from the live request and registered at
  // accept, so mem_* outputs stay frozen for the whole transaction.
  ysyx_23060042_lsu_align #(
    .DW(DW)
  ) u_align (
    .addr_lo    (req_addr[1:0]),
    .size       (req_size),
    .wdata      (req_wdata),
    .lane_wdata (lane_wdata),
    .wstrb      (lane_strb),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state    = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    resp_valid    = 1'b0;
    accept        = 1'b0;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          next_state = misaligned ? RESP : REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) next_state = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          capture    = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_lo_q  <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      wen_q      <= 1'b0;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        addr_lo_q  <= req_addr[1:0];
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        wen_q      <= req_wen;
        mem_addr   <= {req_addr[AW-1:2], 2'b00};
        mem_wen    <= req_wen & ~misaligned;
        mem_wdata  <= lane_wdata;
        mem_wstrb  <= (req_wen & ~misaligned) ? lane_strb : '0;
        resp_rdata <= '0;
        resp_err   <= misaligned;
      end
      if (capture) begin
        resp_rdata <= wen_q ? '0 : lsu_extract(mem_rdata, addr_lo_q, size_q, unsigned_q);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060042_lsu.sv
module tb_ysyx_23060042_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  // Memory side is either the automatic responder or manual stimulus.
  logic        auto_ready = 1'b0;
  logic        auto_resp  = 1'b0;
  logic [31:0] auto_rdata = '0;
  logic        man_mode   = 1'b0;
  logic        man_ready  = 1'b0;
  logic        man_resp   = 1'b0;
  logic [31:0] man_rdata  = '0;

  assign mem_req_ready  = man_mode ? man_ready : auto_ready;
  assign mem_resp_valid = man_mode ? man_resp  : auto_resp;
  assign mem_rdata      = man_mode ? man_rdata : auto_rdata;

  always #5 clk = ~clk;

  ysyx_23060042_lsu #(
    .AW(32),
    .DW(32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_wen        (req_wen),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic        chk_wd;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } memx_t;

  resp_t rq[$];
  memx_t mq[$];

  int total    = 0;
  int bad      = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int done_cnt = 0;
  int mem_reqs = 0;
  int stall_cfg = 0;
  int rhold_cfg = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory responder + response monitor (single process, posedge+1 drive, negedge check).
  initial begin : monitor
    bit          in_req, in_resp, pend, seen, unexp;
    int          scnt, rcnt;
    logic [31:0] pdata;
    memx_t       cur;
    resp_t       e;
    in_req = 0; in_resp = 0; pend = 0; seen = 0; unexp = 0;
    scnt = 0; rcnt = 0; pdata = '0;
    cur.addr = '0; cur.wen = 0; cur.wdata = '0; cur.chk_wd = 0; cur.wstrb = '0; cur.rdata = '0;
    resp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      auto_resp  = 1'b0;
      auto_ready = 1'b0;
      if (pend) begin
        auto_resp  = 1'b1;
        auto_rdata = pdata;
        pend       = 0;
      end
      if (mem_req_valid && !man_mode) begin
        if (!in_req) begin
          in_req = 1;
          scnt   = stall_cfg;
          if (mq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_mem_req: addr %h wen %b, none expected", mem_addr, mem_wen);
            unexp = 1;
            cur.rdata = '0;
          end else begin
            cur = mq.pop_front();
            chk("mem_req_latency", 32'(cyc - acc_cyc), 32'd1);
          end
        end
        if (!unexp) begin
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_wen", {31'b0, mem_wen}, {31'b0, cur.wen});
          chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, cur.wstrb});
          if (cur.chk_wd) chk("mem_wdata", mem_wdata, cur.wdata);
        end
        if (scnt > 0) begin
          scnt--;
        end else begin
          auto_ready = 1'b1;
          pend       = 1;
          pdata      = cur.rdata;
          in_req     = 0;
          unexp      = 0;
          mem_reqs++;
        end
      end
      if (resp_valid) begin
        if (!in_resp) begin
          in_resp = 1;
          rcnt    = rhold_cfg;
        end
        if (rcnt > 0) begin
          resp_ready = 1'b0;
          rcnt--;
        end else begin
          resp_ready = 1'b1;
        end
      end else begin
        in_resp    = 0;
        resp_ready = 1'b1;
      end

      @(negedge clk);
      if (resp_valid) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: rdata %h err %b, none expected", resp_rdata, resp_err);
        end else begin
          e = rq[0];
          if (!seen) begin
            chk("resp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
            seen = 1;
          end
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          if (resp_ready) begin
            void'(rq.pop_front());
            seen = 0;
            done_cnt++;
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat,
                       input logic [31:0] maddr, input logic [31:0] mwd, input logic cwd,
                       input logic [3:0] mstrb, input logic [31:0] mrd, input bit track);
    resp_t r;
    memx_t m;
    int    target;
    bit    got;
    if (track) begin
      r.rdata = er; r.err = ee; r.lat = lat;
      rq.push_back(r);
      if (!ee) begin
        m.addr = maddr; m.wen = w; m.wdata = mwd; m.chk_wd = cwd; m.wstrb = mstrb; m.rdata = mrd;
        mq.push_back(m);
      end
    end
    target = done_cnt + 1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_wen = w; req_size = sz;
    req_unsigned = u; req_wdata = wd;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready %b want 1", req_ready);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (track) begin
      got = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk); #1;
        if (done_cnt >= target) begin got = 1; break; end
      end
      if (!got) begin
        total++; bad++;
        $display("FAIL resp_timeout: done %0d want %0d", done_cnt, target);
      end
    end
  endtask

  initial begin : stimulus
    bit got;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0;
    req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0;

    @(posedge clk); @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    //     addr          w  sz     u  wdata          exp_rdata      err lat  mem_addr       mem_wdata      cwd strb     mem_rdata
    issue(32'h8000_0003, 0, 2'b00, 0, 32'h0,         32'hFFFF_FF80, 0,  3,   32'h8000_0000, 32'h0,         0,  4'b0000, 32'h80FF_1234, 1);
    issue(32'h8000_0002, 0, 2'b01, 1, 32'h0,         32'h0000_BEEF, 0,  3,   32'h8000_0000, 32'h0,         0,  4'b0000, 32'hBEEF_0000, 1);
    issue(32'h8000_0001, 1, 2'b00, 0, 32'h1234_56AB, 32'h0,         0,  3,   32'h8000_0000, 32'h3456_AB00, 1,  4'b0010, 32'hFFFF_FFFF, 1);
    issue(32'h8000_0002, 0, 2'b10, 0, 32'h0,         32'h0,         1,  1,   32'h0,         32'h0,         0,  4'b0000, 32'h0,         1);
    issue(32'h8000_0001, 0, 2'b01, 0, 32'h0,         32'h0,         1,  1,   32'h0,         32'h0,         0,  4'b0000, 32'h0,         1);
    issue(32'h8000_0000, 0, 2'b11, 0, 32'h0,         32'h0,         1,  1,   32'h0,         32'h0,         0,  4'b0000, 32'h0,         1);
    issue(32'h8000_0000, 0, 2'b00, 1, 32'h0,         32'h0000_00F0, 0,  3,   32'h8000_0000, 32'h0,         0,  4'b0000, 32'h1234_56F0, 1);
    issue(32'h8000_0000, 0, 2'b01, 0, 32'h0,         32'hFFFF_8001, 0,  3,   32'h8000_0000, 32'h0,         0,  4'b0000, 32'h0000_8001, 1);
    issue(32'h8000_0008, 0, 2'b10, 1, 32'h0,         32'hDEAD_BEEF, 0,  3,   32'h8000_0008, 32'h0,         0,  4'b0000, 32'hDEAD_BEEF, 1);

    // Backpressure on both sides: 3 request stalls + 2 response stalls.
    stall_cfg = 3; rhold_cfg = 2;
    issue(32'h8000_0006, 1, 2'b01, 0, 32'h0000_CAFE, 32'h0,         0,  6,   32'h8000_0004, 32'hCAFE_0000, 1,  4'b1100, 32'h0,         1);
    issue(32'h8000_0002, 0, 2'b00, 0, 32'h0,         32'hFFFF_FFFE, 0,  6,   32'h8000_0000, 32'h0,         0,  4'b0000, 32'h00FE_0000, 1);
    stall_cfg = 0; rhold_cfg = 0;

    // Reset while waiting for memory; the late response must be dropped.
    man_mode = 1'b1; man_ready = 1'b0; man_resp = 1'b0;
    issue(32'h8000_0000, 0, 2'b10, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req_valid) begin got = 1; break; end
    end
    chk("abort_mem_req_seen", {31'b0, got}, 32'd1);
    man_ready = 1'b1;
    @(posedge clk); #1;
    man_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    man_resp = 1'b1; man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    @(posedge clk); #1;
    man_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("abort_idle", {31'b0, req_ready}, 32'd1);
    end
    man_mode = 1'b0;

    issue(32'h8000_0004, 1, 2'b10, 0, 32'h1122_3344, 32'h0,         0,  3,   32'h8000_0004, 32'h1122_3344, 1,  4'b1111, 32'h0,         1);

    repeat (3) @(negedge clk);
    chk("mem_req_count", 32'(mem_reqs), 32'd9);
    chk("resp_queue_empty", 32'(rq.size()), 32'd0);
    chk("mem_queue_empty", 32'(mq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
